// File: rtl/data_register_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_register_pkg
// Purpose  : Shared constants and types for the data_register block.
//            DATA_W / ADDR_W are the default entry and address widths;
//            data_t / addr_t are convenience types at those widths.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package data_register_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : data_register_pkg
`default_nettype wire

// File: rtl/data_register_entry.sv
`default_nettype none
// ============================================================================
// Module   : data_register_entry
// Purpose  : One storage entry of the register file: a DATA_W-bit flop with
//            asynchronous active-high reset and a local write enable.
// Ports    : clock   - rising-edge clock
//            reset   - async active-high, loads RESET_VAL
//            we_i    - local write enable (already address-decoded)
//            d_i     - data to store
//            q_o     - current entry contents
// Revision : 1.0  initial release
// ============================================================================
module data_register_entry #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q;

  // Reset has priority, so a write strobe on an edge where reset is still
  // high is discarded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VAL;
    end else if (we_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule : data_register_entry
`default_nettype wire

// File: rtl/data_register.sv
`default_nettype none
// ============================================================================
// Module   : data_register
// Purpose  : 2**ADDR_W x DATA_W register file with one synchronous write port
//            and one combinational read port. All entries clear to RESET_VAL
//            on asynchronous active-high reset.
// Ports    : clock        - rising-edge clock for writes
//            reset        - async active-high, clears every entry
//            enable_write - write strobe sampled on rising clock edge
//            write_addr   - entry written when enable_write=1
//            read_addr    - entry driven onto read_data
//            write_data   - value stored at write_addr
//            read_data    - contents of entry read_addr (combinational)
// Revision : 1.0  initial release
// ============================================================================
module data_register #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
);

  import data_register_pkg::*;

  localparam int DEPTH_L = 2 ** ADDR_W;

  logic [DEPTH_L-1:0]             entry_we;
  logic [DEPTH_L-1:0][DATA_W-1:0] entry_q;

  // Address decoder plus one storage entry per address. Every address value
  // maps to an entry, so no range checking is needed.
  generate
    for (genvar i = 0; i < DEPTH_L; i++) begin : g_entry
      assign entry_we[i] = enable_write && (write_addr == ADDR_W'(i));

      data_register_entry #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
      ) u_entry (
        .clock (clock),
        .reset (reset),
        .we_i  (entry_we[i]),
        .d_i   (write_data),
        .q_o   (entry_q[i])
      );
    end
  endgenerate

  // Read straight from storage: no write_data bypass, so a same-address
  // write only becomes visible after the clock edge.
  assign read_data = entry_q[read_addr];

endmodule : data_register
`default_nettype wire

// File: tb/tb_data_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_register
// Purpose  : Self-checking bench for data_register. Stimulus pushes expected
//            read values into a queue; a monitor pops and compares them.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_register;
  import data_register_pkg::*;

  logic  clock = 1'b0;
  logic  reset;
  logic  enable_write;
  addr_t write_addr;
  addr_t read_addr;
  data_t write_data;
  data_t read_data;

  typedef struct {
    addr_t addr;
    data_t exp;
    string name;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  data_register #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .RESET_VAL ('0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable_write (enable_write),
    .write_addr   (write_addr),
    .read_addr    (read_addr),
    .write_data   (write_data),
    .read_data    (read_data)
  );

  // Monitor: each sample strobe means read_data is presenting a value that
  // the stimulus has queued an expectation for.
  always begin
    exp_t e;
    @(sample_ev);
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL monitor_empty: sample with no expected value, read_data=%02h", read_data);
    end else begin
      e = exp_q.pop_front();
      if (read_addr !== e.addr)
        $display("FAIL %s: read_addr=%02h required %02h", e.name, read_addr, e.addr);
      else if (read_data !== e.exp)
        $display("FAIL %s: addr=%02h read_data=%02h required %02h", e.name, e.addr, read_data, e.exp);
      else
        n_pass++;
    end
  end

  task automatic chk(input addr_t a, input data_t exp, input string name);
    exp_t e;
    read_addr = a;
    #1;
    e.addr = a;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
    -> sample_ev;
    #1;
  endtask

  task automatic wr(input addr_t a, input data_t d);
    @(negedge clock);
    enable_write = 1'b1;
    write_addr   = a;
    write_data   = d;
    @(posedge clock);
    #1;
    enable_write = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    enable_write = 1'b0;
    write_addr   = '0;
    write_data   = '0;
    read_addr    = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Reset state
    chk(8'd0,   8'h00, "rst_addr0");
    chk(8'd1,   8'h00, "rst_addr1");
    chk(8'd2,   8'h00, "rst_addr2");
    chk(8'd255, 8'h00, "rst_addr255");

    // Basic write/read
    wr(8'd0, 8'd4);
    wr(8'd1, 8'd5);
    chk(8'd0, 8'd4, "wr_addr0");
    chk(8'd1, 8'd5, "wr_addr1");

    // Write suppression
    @(negedge clock);
    enable_write = 1'b0;
    write_addr   = 8'd2;
    write_data   = 8'd6;
    repeat (3) @(posedge clock);
    #1;
    chk(8'd2, 8'd0, "nowr_addr2");
    chk(8'd0, 8'd4, "nowr_addr0");
    chk(8'd1, 8'd5, "nowr_addr1");

    // Read-during-write to the same address
    @(negedge clock);
    enable_write = 1'b1;
    write_addr   = 8'd7;
    write_data   = 8'hA5;
    chk(8'd7, 8'h00, "rdw_before");
    @(posedge clock);
    #1;
    enable_write = 1'b0;
    chk(8'd7, 8'hA5, "rdw_after");

    // Consecutive writes to the same address: last wins
    wr(8'd9, 8'h31);
    wr(8'd9, 8'h32);
    chk(8'd9, 8'h32, "last_wins");

    // Async reset between edges, write attempted while reset is high
    @(negedge clock);
    #1;
    reset = 1'b1;
    chk(8'd0, 8'h00, "async_rst_addr0");
    enable_write = 1'b1;
    write_addr   = 8'd3;
    write_data   = 8'h77;
    @(posedge clock);
    #1;
    chk(8'd1, 8'h00, "async_rst_addr1");
    chk(8'd3, 8'h00, "wr_in_reset_ignored");
    @(negedge clock);
    reset      = 1'b0;
    write_data = 8'h11;
    chk(8'd7, 8'h00, "async_rst_addr7");
    @(posedge clock);
    #1;
    enable_write = 1'b0;
    chk(8'd3, 8'h11, "first_wr_after_rst");

    // Full sweep
    for (int i = 0; i < DEPTH; i++) begin
      wr(addr_t'(i), data_t'(i) ^ 8'h5A);
    end
    for (int i = 0; i < DEPTH; i++) begin
      chk(addr_t'(i), data_t'(i) ^ 8'h5A, "sweep");
    end
    wr(8'd255, 8'hFF);
    chk(8'd255, 8'hFF, "overwrite_255");
    chk(8'd254, 8'hA4, "untouched_254");

    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d expected values left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_data_register
`default_nettype wire
